sid_frame_player: RTL and testbench

//  Sequences mos6581 register writes from a frame-ordered register dump in sid_mem: one frame of

---
 rtl/sid_pkg.sv | 15 +
 rtl/sid_frame_player_if.sv | 25 ++
 rtl/sid_frame_timer.sv | 37 +++
 rtl/sid_frame_player.sv | 222 ++++++++++++++++++++++
 tb/tb_sid_frame_player.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sid_pkg.sv
// Shared types and constants for the SID frame player.
// Player FSM states plus SID register-file geometry.
package sid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STROBE,
    WAIT_FRAME
  } player_state_t;

  localparam int SID_NUM_REGS = 25;
  localparam int SID_REG_W    = 5;

endpackage

// File: rtl/sid_frame_player_if.sv
// Host write-request channel into the SID frame player.
// valid/addr/data from the host, ready pulses when accepted.
interface sid_frame_player_if;
  import sid_pkg::*;

  logic                 host_valid;
  logic [SID_REG_W-1:0] host_addr;
  logic [7:0]           host_data;
  logic                 host_ready;

  modport master (
    output host_valid,
    output host_addr,
    output host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid,
    input  host_addr,
    input  host_data,
    output host_ready
  );

endinterface

// File: rtl/sid_frame_timer.sv
// Frame period timer: counts clk_en pulses while enabled.
// Ports: slowclk/n_reset, clk_en, en, clear; frame_tick on last pulse.
module sid_frame_timer #(
  parameter int FRAME_TICKS = 20000
) (
  input  logic slowclk,
  input  logic n_reset,
  input  logic clk_en,
  input  logic en,
  input  logic clear,
  output logic frame_tick
);

  localparam int CW = $clog2(FRAME_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign frame_tick = en & clk_en & ~clear
                    & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && clk_en) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge slowclk or negedge n_reset) begin
    if (!n_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sid_frame_player.sv
// Plays a frame-ordered SID register dump, one write per clk_en slot.
// Ports: slowclk/n_reset, clk_en, start/stop, mem_addr/mem_data,
// host (slave), sid_addr/sid_data/sid_n_cs, playing, overrun, frame_cnt.
module sid_frame_player
  import sid_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int REGS_PER_FRAME = SID_NUM_REGS,
  parameter int NUM_FRAMES     = 51,
  parameter int FRAME_TICKS    = 20000
) (
  input  logic                 slowclk,
  input  logic                 n_reset,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic                 stop,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [7:0]           mem_data,
  sid_frame_player_if.slave    host,
  output logic [SID_REG_W-1:0] sid_addr,
  output logic [7:0]           sid_data,
  output logic                 sid_n_cs,
  output logic                 playing,
  output logic                 overrun,
  output logic [15:0]          frame_cnt
);

  localparam logic [SID_REG_W-1:0] REG_LAST =
    SID_REG_W'(REGS_PER_FRAME - 1);
  localparam logic [15:0] FRAME_LAST =
    16'(NUM_FRAMES - 1);

  player_state_t state_q, state_d;
  player_state_t ret_q, ret_d;
  player_state_t eff_state;

  logic                 play_q, play_d;
  logic                 rd_ok_q, rd_ok_d;
  logic                 tick_q, tick_d;
  logic                 over_q, over_d;
  logic                 stpend_q, stpend_d;
  logic                 sppend_q, sppend_d;
  logic                 n_cs_q, n_cs_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [SID_REG_W-1:0] reg_q, reg_d;
  logic [SID_REG_W-1:0] sa_q, sa_d;
  logic [7:0]           sd_q, sd_d;
  logic [15:0]          frame_q, frame_d;

  logic in_strobe, stop_req, start_req, act;
  logic host_go, play_go, strobe_done, frame_go;
  logic frame_tick, tmr_clr;

  // A host strobe parks the playback state in ret_q;
  // eff_state is where playback really is.
  assign eff_state = (state_q == STROBE) ? ret_q : state_q;
  assign in_strobe = (state_q == STROBE);

  assign stop_req  = stop | sppend_q;
  assign start_req = (start | stpend_q) & ~stop_req;
  assign act       = ~in_strobe & (stop_req | start_req);

  assign host_go   = ~in_strobe & ~act & host.host_valid;
  assign play_go   = ~in_strobe & ~act & ~host.host_valid
                   & (state_q == FETCH) & rd_ok_q;
  assign strobe_done = in_strobe & clk_en;
  assign frame_go  = (state_q == WAIT_FRAME) & ~act & ~host_go
                   & (frame_tick | tick_q);

  assign host.host_ready = host_go & n_reset;

  assign mem_addr  = addr_q;
  assign sid_addr  = sa_q;
  assign sid_data  = sd_q;
  assign sid_n_cs  = n_cs_q;
  assign playing   = (eff_state != IDLE);
  assign overrun   = over_q;
  assign frame_cnt = frame_q;

  sid_frame_timer #(
    .FRAME_TICKS (FRAME_TICKS)
  ) u_timer (
    .slowclk    (slowclk),
    .n_reset    (n_reset),
    .clk_en     (clk_en),
    .en         (playing),
    .clear      (tmr_clr),
    .frame_tick (frame_tick)
  );

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    play_d   = play_q;
    rd_ok_d  = rd_ok_q;
    tick_d   = tick_q | frame_tick;
    over_d   = over_q;
    stpend_d = stpend_q;
    sppend_d = sppend_q;
    n_cs_d   = n_cs_q;
    addr_d   = addr_q;
    reg_d    = reg_q;
    sa_d     = sa_q;
    sd_d     = sd_q;
    frame_d  = frame_q;
    tmr_clr  = 1'b0;

    // start/stop during a strobe wait for it to end
    if (in_strobe) begin
      if (stop) begin
        sppend_d = 1'b1;
        stpend_d = 1'b0;
      end else if (start) begin
        stpend_d = 1'b1;
        sppend_d = 1'b0;
      end
    end

    if (frame_tick && eff_state != WAIT_FRAME)
      over_d = 1'b1;

    // first FETCH cycle covers the sid_mem read latency
    if (state_q == FETCH) rd_ok_d = 1'b1;

    unique case (1'b1)
      act: begin
        stpend_d = 1'b0;
        sppend_d = 1'b0;
        if (stop_req) begin
          state_d = IDLE;
        end else begin
          state_d = FETCH;
          reg_d   = '0;
          addr_d  = '0;
          frame_d = '0;
          over_d  = 1'b0;
          tick_d  = 1'b0;
          rd_ok_d = 1'b0;
          tmr_clr = 1'b1;
        end
      end
      host_go: begin
        sa_d    = host.host_addr;
        sd_d    = host.host_data;
        n_cs_d  = 1'b0;
        ret_d   = state_q;
        play_d  = 1'b0;
        state_d = STROBE;
      end
      play_go: begin
        sa_d    = reg_q;
        sd_d    = mem_data;
        n_cs_d  = 1'b0;
        ret_d   = FETCH;
        play_d  = 1'b1;
        state_d = STROBE;
      end
      strobe_done: begin
        n_cs_d  = 1'b1;
        state_d = ret_q;
        if (play_q) begin
          addr_d  = addr_q + ADDR_W'(1);
          rd_ok_d = 1'b0;
          if (reg_q == REG_LAST) begin
            reg_d   = '0;
            state_d = WAIT_FRAME;
          end else begin
            reg_d = reg_q + SID_REG_W'(1);
          end
        end
      end
      frame_go: begin
        state_d = FETCH;
        tick_d  = 1'b0;
        rd_ok_d = 1'b0;
        reg_d   = '0;
        if (frame_q == FRAME_LAST) begin
          frame_d = '0;
          addr_d  = '0;
        end else begin
          frame_d = frame_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge slowclk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      ret_q    <= IDLE;
      play_q   <= 1'b0;
      rd_ok_q  <= 1'b0;
      tick_q   <= 1'b0;
      over_q   <= 1'b0;
      stpend_q <= 1'b0;
      sppend_q <= 1'b0;
      n_cs_q   <= 1'b1;
      addr_q   <= '0;
      reg_q    <= '0;
      sa_q     <= '0;
      sd_q     <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      play_q   <= play_d;
      rd_ok_q  <= rd_ok_d;
      tick_q   <= tick_d;
      over_q   <= over_d;
      stpend_q <= stpend_d;
      sppend_q <= sppend_d;
      n_cs_q   <= n_cs_d;
      addr_q   <= addr_d;
      reg_q    <= reg_d;
      sa_q     <= sa_d;
      sd_q     <= sd_d;
      frame_q  <= frame_d;
    end
  end

endmodule

// File: tb/tb_sid_frame_player.sv
// Bench for sid_frame_player: scoreboard of expected SID writes,
// monitor pops on each n_cs fall and checks one clk_en per strobe.
module tb_sid_frame_player;
  import sid_pkg::*;

  localparam int AW  = 12;
  localparam int RPF = 25;
  localparam int NF  = 2;
  localparam int FT  = 40;

  logic          slowclk = 1'b0;
  logic          n_reset = 1'b0;
  logic          clk_en  = 1'b0;
  logic          start   = 1'b0;
  logic          stop    = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'h00;
  logic [4:0]    sid_addr;
  logic [7:0]    sid_data;
  logic          sid_n_cs;
  logic          playing;
  logic          overrun;
  logic [15:0]   frame_cnt;

  sid_frame_player_if host ();

  sid_frame_player #(
    .ADDR_W         (AW),
    .REGS_PER_FRAME (RPF),
    .NUM_FRAMES     (NF),
    .FRAME_TICKS    (FT)
  ) dut (
    .slowclk   (slowclk),
    .n_reset   (n_reset),
    .clk_en    (clk_en),
    .start     (start),
    .stop      (stop),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .host      (host),
    .sid_addr  (sid_addr),
    .sid_data  (sid_data),
    .sid_n_cs  (sid_n_cs),
    .playing   (playing),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  typedef struct packed {
    logic [4:0]    a;
    logic [7:0]    d;
    logic [AW-1:0] ma;
    logic [15:0]   f;
  } wr_t;

  wr_t           exp_q[$];
  logic [7:0]    mem [64];
  logic [AW-1:0] ram_a;
  int            n_chk  = 0;
  int            n_fail = 0;
  int            en_per = 3;
  int            en_cnt = 0;
  int            n_hr   = 0;

  initial forever #5 slowclk = ~slowclk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // clk_en: one cycle wide every en_per cycles
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge slowclk);
      #1;
      ph = (ph + 1 >= en_per) ? 0 : ph + 1;
      clk_en = (ph == 0);
    end
  end

  initial forever begin
    @(posedge slowclk);
    if (clk_en) en_cnt++;
  end

  // synchronous sid_mem: data one cycle after address
  initial forever begin
    @(posedge slowclk);
    ram_a = mem_addr;
    #1 mem_data = mem[ram_a[5:0]];
  end

  // monitor / scoreboard
  initial begin
    logic prev;
    int   ens;
    wr_t  e;
    prev = 1'b1;
    ens  = 0;
    forever begin
      @(negedge slowclk);
      if (!n_reset) begin
        prev = 1'b1;
        ens  = 0;
      end else begin
        if (host.host_ready) n_hr++;
        if (prev && !sid_n_cs) begin
          chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(sid_addr), 32'(e.a));
            chk("wr_data", 32'(sid_data), 32'(e.d));
            chk("wr_mem_addr", 32'(mem_addr), 32'(e.ma));
            chk("wr_frame", 32'(frame_cnt), 32'(e.f));
          end
          ens = 0;
        end
        if (!prev && sid_n_cs)
          chk("strobe_clk_en", 32'(ens), 32'd1);
        if (!sid_n_cs && clk_en) ens++;
        prev = sid_n_cs;
      end
    end
  end

  task automatic push_play(input int f, input int r);
    wr_t e;
    e.a  = 5'(r);
    e.d  = 8'(f * RPF + r);
    e.ma = AW'(f * RPF + r);
    e.f  = 16'(f);
    exp_q.push_back(e);
  endtask

  task automatic push_host(input logic [4:0] a, input logic [7:0] d,
                           input int ma, input int f);
    wr_t e;
    e.a  = a;
    e.d  = d;
    e.ma = AW'(ma);
    e.f  = 16'(f);
    exp_q.push_back(e);
  endtask

  task automatic wait_wr(input int f, input int r);
    int n;
    n = 0;
    do begin
      @(negedge slowclk);
      n++;
    end while (!(sid_n_cs == 1'b0 && sid_addr == 5'(r)
                 && frame_cnt == 16'(f)) && n < 2000);
    chk($sformatf("wait_f%0d_r%0d", f, r), 32'(n < 2000), 32'd1);
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    int n;
    @(posedge slowclk);
    #1;
    host.host_valid = 1'b1;
    host.host_addr  = a;
    host.host_data  = d;
    n = 0;
    do begin
      @(negedge slowclk);
      n++;
    end while (!host.host_ready && n < 500);
    chk("host_ready_seen", 32'(n < 500), 32'd1);
    @(posedge slowclk);
    #1 host.host_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic with_stop);
    @(posedge slowclk);
    #1;
    start = 1'b1;
    stop  = with_stop;
    @(posedge slowclk);
    #1;
    start  = 1'b0;
    stop   = 1'b0;
    en_cnt = 0;
  endtask

  task automatic stop_now();
    stop = 1'b1;
    @(negedge slowclk);
    stop = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    host.host_valid = 1'b1;
    host.host_addr  = 5'h00;
    host.host_data  = 8'h00;

    // reset values
    repeat (3) @(negedge slowclk);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_sid_addr", 32'(sid_addr), 32'd0);
    chk("rst_sid_data", 32'(sid_data), 32'd0);
    chk("rst_n_cs", 32'(sid_n_cs), 32'd1);
    chk("rst_host_ready", 32'(host.host_ready), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    host.host_valid = 1'b0;
    @(posedge slowclk);
    #1 n_reset = 1'b1;
    repeat (2) @(posedge slowclk);

    // run 1: normal playback, host insert, wrap, stop
    for (int r = 0; r <= 5; r++) push_play(0, r);
    push_host(5'h18, 8'h0F, 6, 0);
    for (int r = 6; r < RPF; r++) push_play(0, r);
    for (int r = 0; r < RPF; r++) push_play(1, r);
    for (int r = 0; r <= 3; r++) push_play(0, r);
    pulse_start(1'b0);
    @(negedge slowclk);
    chk("start_playing", 32'(playing), 32'd1);
    chk("start_mem_addr", 32'(mem_addr), 32'd0);
    wait_wr(0, 5);
    host_write(5'h18, 8'h0F);
    repeat (4) @(negedge slowclk);
    chk("host_ready_once", 32'(n_hr), 32'd1);
    wait_wr(1, 0);
    chk("frame1_at_tick", 32'(en_cnt), 32'(FT));
    chk("no_overrun", 32'(overrun), 32'd0);
    wait_wr(0, 3);
    stop_now();
    repeat (30) @(negedge slowclk);
    chk("stop_playing", 32'(playing), 32'd0);
    chk("stop_n_cs", 32'(sid_n_cs), 32'd1);
    chk("stop_drained", 32'(exp_q.size()), 32'd0);

    // start and stop together: stays idle
    pulse_start(1'b1);
    repeat (20) @(negedge slowclk);
    chk("ss_playing", 32'(playing), 32'd0);
    chk("ss_mem_addr", 32'(mem_addr), 32'd4);

    // host served while idle
    push_host(5'h05, 8'hA5, 4, 0);
    host_write(5'h05, 8'hA5);
    repeat (10) @(negedge slowclk);
    chk("idle_host_ready", 32'(n_hr), 32'd2);
    chk("idle_playing", 32'(playing), 32'd0);
    chk("idle_drained", 32'(exp_q.size()), 32'd0);

    // run 2: slower write cadence overruns the frame period
    en_per = 2;
    for (int r = 0; r < RPF; r++) push_play(0, r);
    for (int r = 0; r <= 2; r++) push_play(1, r);
    pulse_start(1'b0);
    wait_wr(1, 0);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("back_to_back", 32'(en_cnt < 2 * FT), 32'd1);
    wait_wr(1, 2);
    stop_now();
    repeat (20) @(negedge slowclk);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("ovr_stop_idle", 32'(playing), 32'd0);
    chk("ovr_drained", 32'(exp_q.size()), 32'd0);

    // start clears overrun; then reset mid-strobe
    for (int r = 0; r <= 1; r++) push_play(0, r);
    pulse_start(1'b0);
    @(negedge slowclk);
    chk("clr_overrun", 32'(overrun), 32'd0);
    chk("clr_frame", 32'(frame_cnt), 32'd0);
    chk("clr_mem_addr", 32'(mem_addr), 32'd0);
    wait_wr(0, 1);
    #1 n_reset = 1'b0;
    #1;
    chk("arst_n_cs", 32'(sid_n_cs), 32'd1);
    chk("arst_sid_addr", 32'(sid_addr), 32'd0);
    chk("arst_sid_data", 32'(sid_data), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_playing", 32'(playing), 32'd0);
    chk("arst_host_ready", 32'(host.host_ready), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_frame", 32'(frame_cnt), 32'd0);
    repeat (3) @(negedge slowclk);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
